apb_cmd_master: RTL and testbench

- APB master sequencer directly upstream of the APB-to-SPI bridge's APB slave port.
- Accepts single read/write commands on a valid/ready interface and drives one APB transfer per command (SETUP then ACCESS, with PREADY wait states).
- Returns read data, error and timeout status on a valid/ready response interface.
- Lets firmware or a test sequencer load the bridge's write FIFO and drain its read FIFO without hand-toggling APB pins.

---
 rtl/apb_cmd_pkg.sv | 26 ++
 rtl/apb_cmd_master.sv | 105 ++++++++++
 tb/tb_apb_cmd_master.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/apb_cmd_pkg.sv
// Shared types for the APB command master: FSM state encoding and the
// command / response records carried through the sequencer.
package apb_cmd_pkg;

   localparam int APB_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_e;

   typedef struct packed {
      logic             write;
      logic [APB_W-1:0] addr;
      logic [APB_W-1:0] wdata;
   } cmd_t;

   typedef struct packed {
      logic [APB_W-1:0] rdata;
      logic             err;
      logic             timeout;
   } rsp_t;

endpackage

// File: rtl/apb_cmd_master.sv
// APB master sequencer: one valid/ready command becomes one APB transfer
// (SETUP, ACCESS with wait states and optional timeout), then one response.
module apb_cmd_master
   import apb_cmd_pkg::*;
#(
   parameter int WIDTH   = APB_W,
   parameter int TIMEOUT = 16
) (
   input  logic             PCLK,
   input  logic             resetn,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_write,
   input  logic [WIDTH-1:0] cmd_addr,
   input  logic [WIDTH-1:0] cmd_wdata,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_rdata,
   output logic             rsp_err,
   output logic             rsp_timeout,
   output logic             PSEL,
   output logic             PENABLE,
   output logic             PWRITE,
   output logic [WIDTH-1:0] PADDR,
   output logic [WIDTH-1:0] PWDATA,
   input  logic             PREADY,
   input  logic             PSLVERR,
   input  logic [WIDTH-1:0] PRDATA,
   output logic [1:0]       state_dbg
);

   localparam int TO_W = $clog2(TIMEOUT + 2);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   apb_state_e      state;
   cmd_t            cmd_q;
   rsp_t            rsp_q;
   logic [TO_W-1:0] wait_cnt;

   // Handshakes: cmd is taken on a rising edge with cmd_valid && cmd_ready;
   // rsp is consumed on a rising edge with rsp_valid && rsp_ready. Only one
   // command is ever in flight.
   assign cmd_ready   = (state == IDLE) && resetn;
   assign PWRITE      = cmd_q.write;
   assign PADDR       = cmd_q.addr;
   assign PWDATA      = cmd_q.wdata;
   assign rsp_rdata   = rsp_q.rdata;
   assign rsp_err     = rsp_q.err;
   assign rsp_timeout = rsp_q.timeout;
   assign state_dbg   = state;

   always_ff @(posedge PCLK or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
         cmd_q     <= '0;
         rsp_q     <= '0;
         rsp_valid <= 1'b0;
         wait_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  cmd_q    <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
                  PSEL     <= 1'b1;
                  wait_cnt <= '0;
                  state    <= SETUP;
               end
            end
            SETUP: begin
               PENABLE <= 1'b1;
               state   <= ACCESS;
            end
            ACCESS: begin
               // Completion has priority over the timeout on the same cycle.
               if (PREADY) begin
                  rsp_q     <= '{rdata: (cmd_q.write || PSLVERR) ? '0 : PRDATA,
                                 err: PSLVERR, timeout: 1'b0};
                  PSEL      <= 1'b0;
                  PENABLE   <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else if ((TIMEOUT != 0) && (wait_cnt == TO_LAST)) begin
                  rsp_q     <= '{rdata: '0, err: 1'b1, timeout: 1'b1};
                  PSEL      <= 1'b0;
                  PENABLE   <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed and randomized bench for apb_cmd_master with an APB slave model
// and a transaction-level reference for expected responses and timing.
module tb_apb_cmd_master;
   import apb_cmd_pkg::*;

   localparam int W  = 8;
   localparam int TO = 16;

   logic         PCLK = 1'b0;
   logic         resetn;
   logic         cmd_valid, cmd_ready, cmd_write;
   logic [W-1:0] cmd_addr, cmd_wdata;
   logic         rsp_valid, rsp_ready;
   logic [W-1:0] rsp_rdata;
   logic         rsp_err, rsp_timeout;
   logic         PSEL, PENABLE, PWRITE;
   logic [W-1:0] PADDR, PWDATA, PRDATA;
   logic         PREADY, PSLVERR;
   logic [1:0]   state_dbg;

   int n_cmp = 0;
   int n_bad = 0;
   logic [W+1:0] exp_q[$];

   apb_cmd_master #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .PCLK(PCLK), .resetn(resetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA),
      .state_dbg(state_dbg)
   );

   always #5 PCLK = ~PCLK;

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, expected finish before 100us");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One command through the DUT. waits = PREADY-low ACCESS cycles offered
   // by the slave before it answers; hold = cycles of response back-pressure.
   task automatic do_txn(input logic wr, input logic [W-1:0] addr, input logic [W-1:0] wdata,
                         input int waits, input logic slverr, input logic [W-1:0] rdata,
                         input int hold);
      logic         to_hit;
      int           exp_acc, setup_n, acc_n, cyc;
      logic [W+1:0] exp;
      to_hit  = (TO != 0) && (waits >= TO);
      exp_acc = to_hit ? TO : waits + 1;
      if (to_hit)
         exp_q.push_back({{W{1'b0}}, 1'b1, 1'b1});
      else
         exp_q.push_back({(wr || slverr) ? {W{1'b0}} : rdata, slverr, 1'b0});

      @(negedge PCLK);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
      rsp_ready = 1'b0; PREADY = 1'b0;
      check("cmd_ready_idle", cmd_ready, 1);
      @(negedge PCLK);
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom); cmd_addr = W'($urandom); cmd_wdata = W'($urandom);

      setup_n = 0; acc_n = 0; cyc = 1;
      while (rsp_valid !== 1'b1 && cyc < 64) begin
         if (PSEL && !PENABLE) setup_n++;
         if (PSEL && PENABLE) begin
            acc_n++;
            check("paddr_stable", PADDR, addr);
            check("pwrite_stable", PWRITE, wr);
            check("pwdata_stable", PWDATA, wdata);
            PREADY  = (acc_n == waits + 1);
            PSLVERR = PREADY ? slverr : 1'($urandom);
            PRDATA  = PREADY ? rdata : W'($urandom);
         end else begin
            PREADY = 1'b0;
         end
         @(negedge PCLK);
         cyc++;
      end
      PREADY = 1'b0; PSLVERR = 1'b0;

      exp = exp_q.pop_front();
      check("rsp_seen", rsp_valid, 1);
      check("setup_cycles", setup_n, 1);
      check("access_cycles", acc_n, exp_acc);
      check("latency", cyc, exp_acc + 2);
      check("psel_idle_in_resp", {PSEL, PENABLE}, 0);
      check("rsp_rdata", rsp_rdata, exp[W+1:2]);
      check("rsp_err", rsp_err, exp[1]);
      check("rsp_timeout", rsp_timeout, exp[0]);

      // Back-pressure with a competing command that must not be taken.
      cmd_valid = (hold > 0);
      for (int i = 0; i < hold; i++) begin
         @(negedge PCLK);
         check("bp_rsp_valid", rsp_valid, 1);
         check("bp_rsp_fields", {rsp_rdata, rsp_err, rsp_timeout}, exp);
         check("bp_cmd_ready", cmd_ready, 0);
         check("bp_psel", PSEL, 0);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge PCLK);
      rsp_ready = 1'b0;
      check("rsp_valid_drop", rsp_valid, 0);
      check("cmd_ready_after", cmd_ready, 1);
   endtask

   initial begin
      resetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      rsp_ready = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
      #1;
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_apb_ctl", {PSEL, PENABLE, PWRITE}, 0);
      check("rst_paddr_pwdata", {PADDR, PWDATA}, 0);
      check("rst_rsp", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, 0);
      check("rst_state", state_dbg, IDLE);
      repeat (3) @(negedge PCLK);
      resetn = 1'b1;

      // Directed cases from the plan.
      do_txn(1'b1, 8'h01, 8'hA5, 0,  1'b0, 8'h77, 0);
      do_txn(1'b0, 8'h02, 8'h00, 3,  1'b0, 8'h3C, 0);
      do_txn(1'b0, 8'h03, 8'h11, 0,  1'b1, 8'hFF, 0);
      do_txn(1'b0, 8'h04, 8'h22, 16, 1'b0, 8'h5A, 0);
      do_txn(1'b0, 8'h05, 8'h33, 15, 1'b0, 8'h6B, 0);
      do_txn(1'b1, 8'h06, 8'h44, 40, 1'b0, 8'h00, 1);
      do_txn(1'b0, 8'h07, 8'h55, 2,  1'b0, 8'hC3, 5);
      do_txn(1'b1, 8'h08, 8'h66, 0,  1'b0, 8'h00, 0);

      // Asynchronous reset in the middle of ACCESS.
      @(negedge PCLK);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h09; cmd_wdata = 8'h00;
      @(negedge PCLK);
      cmd_valid = 1'b0;
      repeat (3) @(negedge PCLK);
      check("pre_rst_access", {PSEL, PENABLE}, 2'b11);
      @(posedge PCLK);
      #2 resetn = 1'b0;
      #1;
      check("mid_rst_psel", {PSEL, PENABLE}, 0);
      check("mid_rst_rsp_valid", rsp_valid, 0);
      check("mid_rst_cmd_ready", cmd_ready, 0);
      repeat (2) @(negedge PCLK);
      resetn = 1'b1;
      @(negedge PCLK);
      check("post_rst_no_rsp", rsp_valid, 0);
      check("post_rst_no_psel", PSEL, 0);
      do_txn(1'b1, 8'h0A, 8'h9C, 1, 1'b0, 8'h00, 0);

      // Randomized transactions.
      for (int n = 0; n < 24; n++) begin
         do_txn(1'($urandom), W'($urandom), W'($urandom), $urandom_range(0, 19),
                ($urandom_range(0, 3) == 0), W'($urandom), $urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
